counter_sequencer: RTL and testbench
====================================

Name: counter_sequencer

Overview:
Controller that sequences a WIDTH-bit synchronous up/down count register between programmable bounds.
- Supports four run modes: one-shot up, one-shot down, auto-reload, and ping-pong.
- Uses a start/abort/hold control interface and reports status through busy, done, turn and cfg_err.
- Sits between firmware-facing control logic and any consumer of a bounded, direction-controlled count (timers, address walkers, PWM ramps).

Parameters:
WIDTH, 4, bit width of count, cfg_lo, cfg_hi

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  request to begin a sequence; sampled only in IDLE
abort  input  1  terminate the running sequence
hold  input  1  freeze count while running
cfg_mode  input  2  00 one-shot up, 01 one-shot down, 10 auto-reload up, 11 ping-pong
cfg_lo  input  WIDTH  lower bound (unsigned)
cfg_hi  input  WIDTH  upper bound (unsigned)
count  output  WIDTH  current count value
dir  output  1  1 = counting up, 0 = counting down
busy  output  1  high while in RUN
done  output  1  one-cycle pulse on one-shot completion
turn  output  1  one-cycle pulse on wrap (mode 10) or reversal (mode 11)
cfg_err  output  1  one-cycle pulse when start is rejected

Behaviour:
- Reset: on reset=1 at an edge, the block enters IDLE with count=0, dir=1, busy=0, done=0, turn=0, cfg_err=0. Reset overrides all inputs, including mid-RUN.
- States: IDLE and RUN. All outputs are registered.
- done, turn and cfg_err are high for exactly one cycle, then return to 0.
- IDLE:
  - count and dir hold their values.
  - Priority in IDLE: abort > start. If start=1 and abort=1 in the same cycle, nothing happens.
  - If start=1 and cfg_lo >= cfg_hi at the edge: cfg_err=1 next cycle and the block stays IDLE.
  - If start=1 and cfg_lo < cfg_hi: cfg_mode, cfg_lo and cfg_hi are latched internally and the block enters RUN.
  - Start value on entry to RUN: count=cfg_hi for mode 01, count=cfg_lo for all other modes.
  - dir on entry to RUN: dir=0 for mode 01, dir=1 for all other modes.
  - busy=1 from the first RUN cycle.
- Configuration inputs are ignored while busy. start is ignored while busy.
- RUN, per edge, in priority order:
  1. abort=1: go to IDLE; count holds; busy=0; no done pulse.
  2. hold=1: count, dir and state all unchanged.
  3. Mode 00: if count==hi, go to IDLE with done=1 and busy=0, count stays at hi. Otherwise count+1.
  4. Mode 01: if count==lo, go to IDLE with done=1 and busy=0, count stays at lo. Otherwise count-1.
  5. Mode 10: if count==hi, count=lo and turn=1. Otherwise count+1. Runs until abort.
  6. Mode 11:
     - If dir=1 and count==hi: count=hi-1, dir=0, turn=1.
     - If dir=0 and count==lo: count=lo+1, dir=1, turn=1.
     - Otherwise step count in direction dir. Runs until abort.
- Arithmetic: unsigned, modulo 2^WIDTH. Because lo<hi is enforced, count never leaves [lo,hi] in RUN and never wraps past 0 or 2^WIDTH-1.
- Latency:
  - Start accepted at edge N: count shows the start value after edge N.
  - One-shot: done is seen (hi-lo+1) edges after the start value appears, excluding held cycles.
- A start presented in the cycle done is high is accepted, since the block is in IDLE.

Test Plan:
1. Reset mid-RUN (mode 11, count=7) -> next cycle count=0, dir=1, busy=0, done=turn=cfg_err=0.
2. WIDTH=4, mode 00, lo=2, hi=5, start pulse -> count 2,3,4,5 on successive cycles; the next cycle gives done=1, busy=0, count=5; the cycle after gives done=0.
3. Mode 10, lo=13, hi=15 -> 13,14,15,13,14 with turn=1 on the cycle count returns to 13. Assert abort with count=14 -> IDLE, count=14, busy=0, done=0.
4. Mode 11, lo=0, hi=2 -> 0,1,2,1,0,1 with dir 1,1,1,0,0,1 and turn=1 on the cycles count=1 (after 2) and count=1 (after 0). With hold=1 for 3 cycles at count=2 -> 2,2,2 then continues to 1.
5. start with lo=5, hi=5 -> cfg_err=1 for one cycle, busy stays 0. start with abort=1 in IDLE -> no effect. start while busy with a new cfg -> ignored, sequence unchanged.
6. Mode 01, lo=0, hi=15 -> 15 down to 0, then done=1 with count=0 and no wrap to 15. A start in the done cycle with mode 00 is accepted: the next cycle gives count=lo, busy=1.

Source files
------------

// File: rtl/counter_sequencer.sv
// counter_sequencer: bounded up/down count sequencer with one-shot, auto-reload and ping-pong modes
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic             hold,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_lo,
    input  logic [WIDTH-1:0] cfg_hi,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done,
    output logic             turn,
    output logic             cfg_err
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t           state, state_n;
    logic [WIDTH-1:0] count_n, lo_q, hi_q, lo_n, hi_n;
    logic [1:0]       mode_q, mode_n;
    logic             dir_n, done_n, turn_n, err_n;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            count   <= '0;
            dir     <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
            turn    <= 1'b0;
            cfg_err <= 1'b0;
            mode_q  <= 2'b00;
            lo_q    <= '0;
            hi_q    <= '0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            dir     <= dir_n;
            busy    <= state_n == RUN;
            done    <= done_n;
            turn    <= turn_n;
            cfg_err <= err_n;
            mode_q  <= mode_n;
            lo_q    <= lo_n;
            hi_q    <= hi_n;
        end
    end
    always_comb begin
        state_n = state;
        count_n = count;
        dir_n   = dir;
        done_n  = 1'b0;
        turn_n  = 1'b0;
        err_n   = 1'b0;
        mode_n  = mode_q;
        lo_n    = lo_q;
        hi_n    = hi_q;
        if (state == IDLE) begin
            if (start && !abort) begin
                if (cfg_lo >= cfg_hi) begin
                    err_n = 1'b1;
                end else begin
                    state_n = RUN;
                    mode_n  = cfg_mode;
                    lo_n    = cfg_lo;
                    hi_n    = cfg_hi;
                    count_n = (cfg_mode == 2'b01) ? cfg_hi : cfg_lo;
                    dir_n   = cfg_mode != 2'b01;
                end
            end
        end else if (abort) begin
            state_n = IDLE;
        end else if (!hold) begin
            // lo < hi is guaranteed by the start check, so no step here can wrap
            case (mode_q)
                2'b00: begin
                    if (count == hi_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        count_n = count + 1'b1;
                    end
                end
                2'b01: begin
                    if (count == lo_q) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end else begin
                        count_n = count - 1'b1;
                    end
                end
                2'b10: begin
                    count_n = (count == hi_q) ? lo_q : count + 1'b1;
                    turn_n  = count == hi_q;
                end
                default: begin
                    if (dir && count == hi_q) begin
                        count_n = hi_q - 1'b1;
                        dir_n   = 1'b0;
                        turn_n  = 1'b1;
                    end else if (!dir && count == lo_q) begin
                        count_n = lo_q + 1'b1;
                        dir_n   = 1'b1;
                        turn_n  = 1'b1;
                    end else begin
                        count_n = dir ? count + 1'b1 : count - 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed plus randomized checks of counter_sequencer against a step-index model
module tb_counter_sequencer;
    localparam int W = 4;
    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic         hold = 1'b0;
    logic [1:0]   cfg_mode = 2'b00;
    logic [W-1:0] cfg_lo = '0;
    logic [W-1:0] cfg_hi = '0;
    logic [W-1:0] count;
    logic         dir, busy, done, turn, cfg_err;
    logic [8:0]   obs;
    int           checks = 0;
    int           fails = 0;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .hold(hold),
        .cfg_mode(cfg_mode), .cfg_lo(cfg_lo), .cfg_hi(cfg_hi),
        .count(count), .dir(dir), .busy(busy), .done(done), .turn(turn), .cfg_err(cfg_err)
    );

    assign obs = {count, dir, busy, done, turn, cfg_err};
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [1:0] m, input int lo, input int hi);
        cfg_mode = m;
        cfg_lo = W'(lo);
        cfg_hi = W'(hi);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected {count,dir,busy,done,turn,cfg_err} after k non-held steps from the start value
    task automatic ref_state(input logic [1:0] m, input int lo, input int hi, input int k, output logic [8:0] e);
        int span, p, c;
        bit d, b, dn, t;
        span = hi - lo;
        d = 1; b = 1; dn = 0; t = 0; c = lo;
        case (m)
            2'd0: begin c = (k <= span) ? lo + k : hi; b = k <= span; dn = k == span + 1; end
            2'd1: begin c = (k <= span) ? hi - k : lo; d = 0; b = k <= span; dn = k == span + 1; end
            2'd2: begin p = k % (span + 1); c = lo + p; t = k > 0 && p == 0; end
            default: begin
                p = k % (2 * span);
                c = (p <= span) ? lo + p : hi - (p - span);
                d = k == 0 || (p >= 1 && p <= span);
                t = (k > span && p == (span + 1) % (2 * span)) || (k > 1 && p == 1);
            end
        endcase
        e = {W'(c), d, b, dn, t, 1'b0};
    endtask

    task automatic test_reset();
        logic [8:0] e;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e = {4'd0, 1'b1, 4'b0000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL reset_idle: got %b expected %b", obs, e); end
        launch(2'd3, 3, 9);
        repeat (4) tick();
        e = {4'd7, 1'b1, 1'b1, 3'b000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL pre_reset_run: got %b expected %b", obs, e); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        e = {4'd0, 1'b1, 4'b0000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL reset_mid_run: got %b expected %b", obs, e); end
    endtask

    task automatic test_oneshot_up();
        logic [8:0] e;
        launch(2'd0, 2, 5);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick();
            e = {W'(2 + i), 1'b1, 1'b1, 3'b000};
            checks++;
            if (obs !== e) begin fails++; $display("FAIL up_step%0d: got %b expected %b", i, obs, e); end
        end
        tick();
        e = {4'd5, 1'b1, 1'b0, 1'b1, 2'b00};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL up_done: got %b expected %b", obs, e); end
        tick();
        e = {4'd5, 1'b1, 4'b0000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL up_done_clear: got %b expected %b", obs, e); end
    endtask

    task automatic test_autoreload();
        logic [8:0] e;
        int vals[5] = '{13, 14, 15, 13, 14};
        launch(2'd2, 13, 15);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) tick();
            e = {W'(vals[i]), 1'b1, 1'b1, 1'b0, i == 3, 1'b0};
            checks++;
            if (obs !== e) begin fails++; $display("FAIL reload_step%0d: got %b expected %b", i, obs, e); end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        e = {4'd14, 1'b1, 4'b0000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL reload_abort: got %b expected %b", obs, e); end
    endtask

    task automatic test_pingpong();
        logic [8:0] e;
        int vals[6] = '{0, 1, 2, 1, 0, 1};
        bit dirs[6] = '{1, 1, 1, 0, 0, 1};
        launch(2'd3, 0, 2);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            e = {W'(vals[i]), dirs[i], 1'b1, 1'b0, i == 3 || i == 5, 1'b0};
            checks++;
            if (obs !== e) begin fails++; $display("FAIL pp_step%0d: got %b expected %b", i, obs, e); end
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        launch(2'd3, 0, 2);
        repeat (2) tick();
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            e = {4'd2, 1'b1, 1'b1, 3'b000};
            checks++;
            if (obs !== e) begin fails++; $display("FAIL pp_hold%0d: got %b expected %b", i, obs, e); end
        end
        hold = 1'b0;
        tick();
        e = {4'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL pp_after_hold: got %b expected %b", obs, e); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        e = {4'd1, 1'b0, 4'b0000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL pp_abort: got %b expected %b", obs, e); end
    endtask

    task automatic test_cfg_err();
        logic [8:0] e;
        int vals[4] = '{1, 2, 3, 0};
        reset = 1'b1;
        tick();
        reset = 1'b0;
        launch(2'd0, 5, 5);
        e = {4'd0, 1'b1, 3'b000, 1'b1};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL err_equal: got %b expected %b", obs, e); end
        tick();
        e = {4'd0, 1'b1, 4'b0000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL err_clear: got %b expected %b", obs, e); end
        launch(2'd2, 9, 3);
        e = {4'd0, 1'b1, 3'b000, 1'b1};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL err_inverted: got %b expected %b", obs, e); end
        abort = 1'b1;
        launch(2'd0, 1, 4);
        abort = 1'b0;
        e = {4'd0, 1'b1, 4'b0000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL start_with_abort: got %b expected %b", obs, e); end
        launch(2'd2, 0, 3);
        cfg_mode = 2'd1;
        cfg_lo = 4'd8;
        cfg_hi = 4'd12;
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            e = {W'(vals[i]), 1'b1, 1'b1, 1'b0, i == 3, 1'b0};
            checks++;
            if (obs !== e) begin fails++; $display("FAIL busy_ignore%0d: got %b expected %b", i, obs, e); end
        end
        start = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_oneshot_down();
        logic [8:0] e;
        launch(2'd1, 0, 15);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) tick();
            e = {W'(15 - i), 1'b0, 1'b1, 3'b000};
            checks++;
            if (obs !== e) begin fails++; $display("FAIL down_step%0d: got %b expected %b", i, obs, e); end
        end
        tick();
        e = {4'd0, 1'b0, 1'b0, 1'b1, 2'b00};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL down_done: got %b expected %b", obs, e); end
        launch(2'd0, 4, 9);
        e = {4'd4, 1'b1, 1'b1, 3'b000};
        checks++;
        if (obs !== e) begin fails++; $display("FAIL start_in_done: got %b expected %b", obs, e); end
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_random();
        logic [8:0] e, last;
        logic [1:0] m;
        int lo, hi, k, limit;
        bit held;
        for (int n = 0; n < 40; n++) begin
            m = 2'($urandom_range(0, 3));
            lo = $urandom_range(0, 14);
            hi = $urandom_range(lo + 1, 15);
            launch(m, lo, hi);
            k = 0;
            ref_state(m, lo, hi, k, e);
            checks++;
            if (obs !== e) begin fails++; $display("FAIL rand%0d_start: got %b expected %b", n, obs, e); end
            limit = (m < 2) ? hi - lo + 1 : 12 + $urandom_range(0, 12);
            while (k < limit) begin
                hold = ($urandom_range(0, 3) == 0);
                held = hold;
                tick();
                if (!held) k++;
                ref_state(m, lo, hi, k, e);
                if (held) e[2:1] = 2'b00;
                checks++;
                if (obs !== e) begin fails++; $display("FAIL rand%0d_k%0d mode%0d lo%0d hi%0d: got %b expected %b", n, k, m, lo, hi, obs, e); end
            end
            hold = 1'b0;
            last = e;
            if (m < 2) begin
                tick();
                e = {last[8:4], 4'b0000};
            end else begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                e = {last[8:4], 4'b0000};
            end
            checks++;
            if (obs !== e) begin fails++; $display("FAIL rand%0d_end: got %b expected %b", n, obs, e); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        tick();
        test_reset();
        test_oneshot_up();
        test_autoreload();
        test_pingpong();
        test_cfg_err();
        test_oneshot_down();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
